even_parity_check_unit: RTL and testbench

- Registered even-parity checker: takes a DATA_W-bit data word plus one parity bit and flags any word whose total count of ones is odd.
- The combinational core is the XOR-tree function out = XOR of all data bits and the parity bit, the same function as the standalone 3+1-input checker (A^B^C^P).
- Sits at a receive-side link/bus boundary. Adds a valid handshake, a 1-cycle registered result and a saturating error counter for status reporting.

---
 rtl/even_parity_check_unit.sv | 90 +++++++++
 tb/tb_even_parity_check_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/even_parity_check_unit.sv
// Registered even-parity checker with valid handshake and saturating error counter.
// Optional build macro PARITY_STICKY_ERR_EN adds a sticky_err status output.

module parity_xor_tree #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_bits,
    output logic         o_p
);
    assign o_p = ^i_bits;
endmodule

module even_parity_check_unit #(
    parameter int DATA_W    = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    data,
    input  logic                 parity_bit,
    input  logic                 clr_count,
    output logic                 out_valid,
    output logic                 parity_out,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef PARITY_STICKY_ERR_EN
    ,
    output logic                 sticky_err
`endif
);
    localparam int STAGES = 1;

    logic                 w_p;
    logic                 w_err_in;
    logic [STAGES:1]      r_vld_pipe;
    logic                 r_parity;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    parity_xor_tree #(.W(DATA_W + 1)) u_xor (
        .i_bits ({data, parity_bit}),
        .o_p    (w_p)
    );

    // Qualify with in_valid first so X on an idle bus never reaches state.
    assign w_err_in = in_valid & w_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_parity   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe, in_valid} >> 0;
            r_err      <= w_err_in;
            if (in_valid)
                r_parity <= w_p;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err_count <= '0;
        else if (clr_count)
            r_err_count <= '0;
        else if (w_err_in && (r_err_count != {ERR_CNT_W{1'b1}}))
            r_err_count <= r_err_count + 1'b1;
    end

`ifdef PARITY_STICKY_ERR_EN
    logic r_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sticky <= 1'b0;
        else if (clr_count)
            r_sticky <= 1'b0;
        else if (w_err_in)
            r_sticky <= 1'b1;
    end

    assign sticky_err = r_sticky;
`endif

    assign out_valid  = r_vld_pipe[STAGES];
    assign parity_out = r_parity;
    assign err        = r_err;
    assign err_count  = r_err_count;
endmodule

// File: tb/tb_even_parity_check_unit.sv
// Directed table-driven bench for even_parity_check_unit (default widths plus a 2-bit counter copy).

module tb_even_parity_check_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] data;
    logic       parity_bit;
    logic       clr_count;
    logic       out_valid, parity_out, err;
    logic [7:0] err_count;
    logic       out_valid2, parity_out2, err2;
    logic [1:0] err_count2;
`ifdef PARITY_STICKY_ERR_EN
    logic       sticky_err, sticky_err2;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    even_parity_check_unit #(.DATA_W(3), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data(data),
        .parity_bit(parity_bit), .clr_count(clr_count),
        .out_valid(out_valid), .parity_out(parity_out), .err(err),
        .err_count(err_count)
`ifdef PARITY_STICKY_ERR_EN
        , .sticky_err(sticky_err)
`endif
    );

    even_parity_check_unit #(.DATA_W(3), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data(data),
        .parity_bit(parity_bit), .clr_count(clr_count),
        .out_valid(out_valid2), .parity_out(parity_out2), .err(err2),
        .err_count(err_count2)
`ifdef PARITY_STICKY_ERR_EN
        , .sticky_err(sticky_err2)
`endif
    );

    typedef struct {
        logic [2:0] d;
        logic       p;
        logic       exp;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] d, input logic p, input logic c);
        in_valid   = v;
        data       = d;
        parity_bit = p;
        clr_count  = c;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_cnt;
        int sat_exp[6];
        logic [2:0] rd;
        logic       rp;

        // {data, P} -> 1 exactly when the four bits hold an odd count of ones
        tbl[0]  = '{3'b000, 1'b0, 1'b0};  tbl[1]  = '{3'b000, 1'b1, 1'b1};
        tbl[2]  = '{3'b001, 1'b0, 1'b1};  tbl[3]  = '{3'b001, 1'b1, 1'b0};
        tbl[4]  = '{3'b010, 1'b0, 1'b1};  tbl[5]  = '{3'b010, 1'b1, 1'b0};
        tbl[6]  = '{3'b011, 1'b0, 1'b0};  tbl[7]  = '{3'b011, 1'b1, 1'b1};
        tbl[8]  = '{3'b100, 1'b0, 1'b1};  tbl[9]  = '{3'b100, 1'b1, 1'b0};
        tbl[10] = '{3'b101, 1'b0, 1'b0};  tbl[11] = '{3'b101, 1'b1, 1'b1};
        tbl[12] = '{3'b110, 1'b0, 1'b0};  tbl[13] = '{3'b110, 1'b1, 1'b1};
        tbl[14] = '{3'b111, 1'b0, 1'b1};  tbl[15] = '{3'b111, 1'b1, 1'b0};
        sat_exp = '{1, 2, 3, 3, 3, 3};

        rst = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_err_count", err_count, 8'd0);
        #11 rst = 1'b0;

        // Build err_count=5, out_valid=1, then reset mid-cycle
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 3'b001, 1'b0, 1'b0);
            step();
        end
        check("pre_rst_count", err_count, 8'd5);
        check("pre_rst_valid", out_valid, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_parity", parity_out, 1'b0);
        check("async_rst_err", err, 1'b0);
        check("async_rst_count", err_count, 8'd0);
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        #2 rst = 1'b0;
        step();
        check("post_rst_valid", out_valid, 1'b0);

        // Exhaustive truth table
        exp_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, tbl[i].d, tbl[i].p, 1'b0);
            step();
            if (tbl[i].exp) exp_cnt++;
            check($sformatf("tt_parity[%0d]", i), parity_out, tbl[i].exp);
            check($sformatf("tt_err[%0d]", i), err, tbl[i].exp);
            check($sformatf("tt_valid[%0d]", i), out_valid, 1'b1);
            check($sformatf("tt_count[%0d]", i), err_count, exp_cnt[7:0]);
        end
        check("tt_final_count", err_count, 8'd8);

        // Handshake: alternate valid/idle, idle bus carries X
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3'b100, 1'b0, 1'b0);
            step();
            exp_cnt++;
            check("hs_valid_hi", out_valid, 1'b1);
            check("hs_err_hi", err, 1'b1);
            check("hs_parity_hi", parity_out, 1'b1);
            drive(1'b0, 3'bxxx, 1'bx, 1'b0);
            step();
            check("hs_valid_lo", out_valid, 1'b0);
            check("hs_err_lo", err, 1'b0);
            check("hs_parity_hold", parity_out, 1'b1);
            check("hs_count", err_count, exp_cnt[7:0]);
        end

        // Saturation on the 2-bit counter instance
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        step();
        check("sat_cleared", err_count2, 2'd0);
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 3'b111, 1'b0, 1'b0);
            step();
            check($sformatf("sat_count[%0d]", k), err_count2, sat_exp[k][1:0]);
        end

        // Clear beats a simultaneous errored word
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'b010, 1'b0, 1'b0);
            step();
        end
        check("clr_pre_count", err_count, 8'd3);
`ifdef PARITY_STICKY_ERR_EN
        check("sticky_pre", sticky_err, 1'b1);
`endif
        drive(1'b1, 3'b010, 1'b0, 1'b1);
        step();
        check("clr_count_zero", err_count, 8'd0);
        check("clr_err_still", err, 1'b1);
`ifdef PARITY_STICKY_ERR_EN
        check("sticky_cleared", sticky_err, 1'b0);
`endif
        drive(1'b1, 3'b010, 1'b0, 1'b0);
        step();
        check("clr_next_count", err_count, 8'd1);
`ifdef PARITY_STICKY_ERR_EN
        check("sticky_reset", sticky_err, 1'b1);
`endif
        drive(1'b1, 3'b011, 1'b0, 1'b0);
        step();
        check("ok_word_err", err, 1'b0);
        check("ok_word_count", err_count, 8'd1);
`ifdef PARITY_STICKY_ERR_EN
        check("sticky_holds", sticky_err, 1'b1);
`endif

        // No-stall random stream
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        step();
        exp_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            rd = 3'($urandom_range(0, 7));
            rp = 1'($urandom_range(0, 1));
            drive(1'b1, rd, rp, 1'b0);
            step();
            if (^{rd, rp} && exp_cnt < 255) exp_cnt++;
            check($sformatf("rs_valid[%0d]", k), out_valid, 1'b1);
            check($sformatf("rs_parity[%0d]", k), parity_out, ^{rd, rp});
        end
        check("rs_final_count", err_count, exp_cnt[7:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
